// File: rtl/frame_sequencer_if.sv
// Start/finished handshake bundle between the frame sequencer (master) and
// its FPS limiter, simulation-step unit and renderer (slave side).
interface frame_sequencer_if #(
  parameter int DELAY_WIDTH = 26
);
  logic                   limit_start;
  logic                   limit_finished;
  logic [DELAY_WIDTH-1:0] limit_delay;
  logic                   step_start;
  logic                   step_finished;
  logic                   draw_start;
  logic                   draw_finished;

  modport master (
    output limit_start,
    output limit_delay,
    output step_start,
    output draw_start,
    input  limit_finished,
    input  step_finished,
    input  draw_finished
  );

  modport slave (
    input  limit_start,
    input  limit_delay,
    input  step_start,
    input  draw_start,
    output limit_finished,
    output step_finished,
    output draw_finished
  );
endinterface

// File: rtl/frame_sequencer.sv
// Frame sequencer: launches limiter and step together, then the draw, and
// closes the frame once the limiter has expired. Counts frames and overruns.
module frame_sequencer #(
  parameter int DELAY_WIDTH = 26,
  parameter int FRAME_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   run,
  input  logic [DELAY_WIDTH-1:0] delay,
  frame_sequencer_if.master      bus,
  output logic                   busy,
  output logic                   frame_done,
  output logic [FRAME_WIDTH-1:0] frame_count,
  output logic [FRAME_WIDTH-1:0] overrun_count
);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    STEP_WAIT,
    DRAW_LAUNCH,
    DRAW_WAIT,
    SYNC
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic                   all_ready;
  logic                   launch;
  logic                   draw_end;
  logic                   frame_end;
  logic [DELAY_WIDTH-1:0] delay_q;

  // A frame may only launch when every target is idle, so starts never hit a busy target.
  assign all_ready = bus.limit_finished & bus.step_finished & bus.draw_finished;
  assign launch    = (state == IDLE) & run & all_ready;
  assign draw_end  = (state == DRAW_WAIT) & bus.draw_finished;
  assign frame_end = (state == SYNC) & bus.limit_finished;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (launch) begin
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        state_next = STEP_WAIT;
      end
      STEP_WAIT: begin
        if (bus.step_finished) begin
          state_next = DRAW_LAUNCH;
        end
      end
      DRAW_LAUNCH: begin
        state_next = DRAW_WAIT;
      end
      DRAW_WAIT: begin
        if (bus.draw_finished) begin
          state_next = SYNC;
        end
      end
      SYNC: begin
        if (bus.limit_finished) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Start pulses come from the state alone so they can never glitch on target inputs.
  always_comb begin
    bus.limit_start = 1'b0;
    bus.step_start  = 1'b0;
    bus.draw_start  = 1'b0;
    busy            = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
      end
      LAUNCH: begin
        bus.limit_start = 1'b1;
        bus.step_start  = 1'b1;
      end
      DRAW_LAUNCH: begin
        bus.draw_start = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      delay_q       <= '0;
      frame_done    <= 1'b0;
      frame_count   <= '0;
      overrun_count <= '0;
    end else begin
      frame_done <= frame_end;
      if (launch) begin
        delay_q <= delay;
      end
      if (frame_end) begin
        frame_count <= frame_count + FRAME_WIDTH'(1);
      end
      // Limiter already expired when the draw completes means the frame ran long.
      if (draw_end && bus.limit_finished) begin
        overrun_count <= overrun_count + FRAME_WIDTH'(1);
      end
    end
  end

  assign bus.limit_delay = delay_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: behavioural limiter/step/draw responders plus a
// frame-level model predicting completion edge, counters and latched delays.
module tb_frame_sequencer;
  localparam int DW     = 26;
  localparam int FW     = 16;
  localparam int BUDGET = 3000;

  logic          clock = 1'b0;
  logic          reset;
  logic          run;
  logic          run2;
  logic [DW-1:0] delay;
  logic [DW-1:0] delay2;
  logic          busy;
  logic          frame_done;
  logic [FW-1:0] frame_count;
  logic [FW-1:0] overrun_count;
  logic          busy2;
  logic          frame_done2;
  logic [1:0]    frame_count2;
  logic [1:0]    overrun_count2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  frame_sequencer_if #(.DELAY_WIDTH(DW)) bus ();
  frame_sequencer_if #(.DELAY_WIDTH(DW)) bus2 ();

  frame_sequencer #(.DELAY_WIDTH(DW), .FRAME_WIDTH(FW)) u_dut (
    .clock(clock), .reset(reset), .run(run), .delay(delay), .bus(bus),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count),
    .overrun_count(overrun_count)
  );

  frame_sequencer #(.DELAY_WIDTH(DW), .FRAME_WIDTH(2)) u_dut_wrap (
    .clock(clock), .reset(reset), .run(run2), .delay(delay2), .bus(bus2),
    .busy(busy2), .frame_done(frame_done2), .frame_count(frame_count2),
    .overrun_count(overrun_count2)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Responders: finished drops on the edge sampling start and stays low lat+1 cycles.
  logic          lim_fin  = 1'b1;
  logic          step_fin = 1'b1;
  logic          draw_fin = 1'b1;
  int            lim_cnt = 0, step_cnt = 0, draw_cnt = 0;
  int            step_lat = 1, draw_lat = 1;
  int            lim_rises = 0, draw_rises = 0;
  int            lim_rise_edge = 0, draw_rise_edge = 0;
  logic [DW-1:0] delay_sampled = '0;

  always @(posedge clock) begin
    if (bus.limit_start) begin
      lim_fin <= 1'b0;
      lim_cnt <= int'(bus.limit_delay);
    end else if (!lim_fin) begin
      if (lim_cnt == 0) begin
        lim_fin       <= 1'b1;
        lim_rises     <= lim_rises + 1;
        lim_rise_edge <= cyc;
      end else begin
        lim_cnt <= lim_cnt - 1;
      end
    end
  end

  always @(posedge clock) begin
    if (bus.step_start) begin
      step_fin <= 1'b0;
      step_cnt <= step_lat;
    end else if (!step_fin) begin
      if (step_cnt == 0) step_fin <= 1'b1;
      else step_cnt <= step_cnt - 1;
    end
  end

  always @(posedge clock) begin
    if (bus.draw_start) begin
      draw_fin <= 1'b0;
      draw_cnt <= draw_lat;
    end else if (!draw_fin) begin
      if (draw_cnt == 0) begin
        draw_fin       <= 1'b1;
        draw_rises     <= draw_rises + 1;
        draw_rise_edge <= cyc;
      end else begin
        draw_cnt <= draw_cnt - 1;
      end
    end
  end

  always @(posedge clock) delay_sampled <= delay;

  assign bus.limit_finished  = lim_fin;
  assign bus.step_finished   = step_fin;
  assign bus.draw_finished   = draw_fin;
  assign bus2.limit_finished = 1'b1;
  assign bus2.step_finished  = 1'b1;
  assign bus2.draw_finished  = 1'b1;

  // Frame model: a frame closes one edge after both the draw completion has been seen
  // and the limiter has expired; overrun when the limiter expired no later than the draw.
  int            limit_starts = 0, step_starts = 0, draw_starts = 0, done_count = 0, proto_errs = 0;
  int            model_frames = 0, model_overruns = 0;
  bit            frame_active = 0, draw_started = 0, draw_seen = 0, ovr_pending = 0, have_edge = 0;
  int            lim_base = 0, draw_base = 0, kd = 0, done_edge = 0;
  int            exp_done_q[$];
  int            obs_done_q[$];
  logic [DW-1:0] exp_delay_q[$];
  logic [DW-1:0] obs_delay_q[$];
  logic [DW-1:0] done_delay_q[$];

  always @(negedge clock) begin
    if (reset) begin
      model_frames   = 0;
      model_overruns = 0;
      frame_active   = 0;
    end else begin
      if (bus.limit_start) begin
        limit_starts++;
        if (!lim_fin || !step_fin || !draw_fin) proto_errs++;
        exp_delay_q.push_back(delay_sampled);
        obs_delay_q.push_back(bus.limit_delay);
        frame_active = 1;
        draw_started = 0;
        draw_seen    = 0;
        have_edge    = 0;
        lim_base     = lim_rises;
      end
      if (bus.step_start) step_starts++;
      if (bus.draw_start) begin
        draw_starts++;
        if (!draw_fin) proto_errs++;
        draw_started = 1;
        draw_base    = draw_rises;
      end
      if (frame_active && draw_started && !draw_seen && draw_rises > draw_base) begin
        draw_seen   = 1;
        kd          = draw_rise_edge;
        ovr_pending = (lim_rises > lim_base);
      end
      if (frame_active && draw_seen && !have_edge && lim_rises > lim_base) begin
        have_edge = 1;
        done_edge = (kd + 2 > lim_rise_edge + 1) ? kd + 2 : lim_rise_edge + 1;
      end
      if (frame_active && have_edge && (cyc - 1) == done_edge) begin
        exp_done_q.push_back(done_edge);
        model_frames++;
        if (ovr_pending) model_overruns++;
        frame_active = 0;
      end
      if (frame_done) begin
        done_count++;
        obs_done_q.push_back(cyc - 1);
        done_delay_q.push_back(bus.limit_delay);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    run   = 1'b0;
    run2  = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic run_frames(input int n, output bit timed_out);
    int target_l;
    int target_d;
    target_l = limit_starts + n;
    target_d = done_count + n;
    run = 1'b1;
    for (int i = 0; i < BUDGET && limit_starts < target_l; i++) tick();
    run = 1'b0;
    for (int i = 0; i < BUDGET && done_count < target_d; i++) tick();
    timed_out = (limit_starts < target_l) || (done_count < target_d);
    tick(3);
  endtask

  task automatic test_reset();
    int l0;
    @(negedge clock);
    reset = 1'b1;
    run   = 1'b1;
    delay = DW'(9);
    #1;
    checks++; if (bus.limit_start !== 1'b0) begin failures++; $display("FAIL reset_limit_start: got %b expected 0", bus.limit_start); end
    checks++; if (bus.step_start !== 1'b0) begin failures++; $display("FAIL reset_step_start: got %b expected 0", bus.step_start); end
    checks++; if (bus.draw_start !== 1'b0) begin failures++; $display("FAIL reset_draw_start: got %b expected 0", bus.draw_start); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    checks++; if (frame_count !== '0) begin failures++; $display("FAIL reset_frame_count: got %0d expected 0", frame_count); end
    checks++; if (overrun_count !== '0) begin failures++; $display("FAIL reset_overrun_count: got %0d expected 0", overrun_count); end
    checks++; if (bus.limit_delay !== '0) begin failures++; $display("FAIL reset_limit_delay: got %0d expected 0", bus.limit_delay); end
    run   = 1'b0;
    reset = 1'b0;
    l0    = limit_starts;
    tick(8);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b expected 0", busy); end
    checks++; if (limit_starts !== l0) begin failures++; $display("FAIL idle_no_launch: got %0d launches expected 0", limit_starts - l0); end
  endtask

  task automatic test_single_frame();
    int l0, s0, d0, c0, e0, p0;
    bit to;
    do_reset();
    delay = DW'(10); step_lat = 1; draw_lat = 1;
    l0 = limit_starts; s0 = step_starts; d0 = draw_starts; c0 = obs_done_q.size(); e0 = exp_done_q.size(); p0 = proto_errs;
    run_frames(1, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL single_timeout: got %b expected 0", to); end
    checks++; if (limit_starts - l0 !== 1) begin failures++; $display("FAIL single_limit_pulses: got %0d expected 1", limit_starts - l0); end
    checks++; if (step_starts - s0 !== 1) begin failures++; $display("FAIL single_step_pulses: got %0d expected 1", step_starts - s0); end
    checks++; if (draw_starts - d0 !== 1) begin failures++; $display("FAIL single_draw_pulses: got %0d expected 1", draw_starts - d0); end
    checks++; if (obs_done_q.size() - c0 !== 1) begin failures++; $display("FAIL single_frame_done: got %0d pulses expected 1", obs_done_q.size() - c0); end
    checks++; if (bus.limit_delay !== DW'(10)) begin failures++; $display("FAIL single_limit_delay: got %0d expected 10", bus.limit_delay); end
    checks++; if (frame_count !== FW'(1)) begin failures++; $display("FAIL single_frame_count: got %0d expected 1", frame_count); end
    checks++; if (overrun_count !== FW'(0)) begin failures++; $display("FAIL single_overrun_count: got %0d expected 0", overrun_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_after: got %b expected 0", busy); end
    checks++; if (proto_errs !== p0) begin failures++; $display("FAIL single_protocol: got %0d violations expected 0", proto_errs - p0); end
    checks++;
    if (obs_done_q.size() <= c0 || exp_done_q.size() <= e0) begin
      failures++; $display("FAIL single_done_edge: got %0d records expected %0d", obs_done_q.size() - c0, exp_done_q.size() - e0);
    end else if (obs_done_q[c0] !== exp_done_q[e0]) begin
      failures++; $display("FAIL single_done_edge: got edge %0d expected %0d", obs_done_q[c0], exp_done_q[e0]);
    end
  endtask

  task automatic test_overrun();
    int l0, d0;
    bit to;
    do_reset();
    delay = DW'(3); step_lat = 1; draw_lat = 19;
    l0 = limit_starts; d0 = draw_starts;
    run_frames(1, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL overrun_timeout: got %b expected 0", to); end
    checks++; if (overrun_count !== FW'(1)) begin failures++; $display("FAIL overrun_count: got %0d expected 1", overrun_count); end
    checks++; if (frame_count !== FW'(1)) begin failures++; $display("FAIL overrun_frame_count: got %0d expected 1", frame_count); end
    checks++; if (limit_starts - l0 !== 1) begin failures++; $display("FAIL overrun_limit_pulses: got %0d expected 1", limit_starts - l0); end
    checks++; if (draw_starts - d0 !== 1) begin failures++; $display("FAIL overrun_draw_pulses: got %0d expected 1", draw_starts - d0); end
  endtask

  task automatic test_delay_change();
    int l0, c0;
    do_reset();
    delay = DW'(7); step_lat = 2; draw_lat = 3;
    l0 = obs_delay_q.size(); c0 = done_delay_q.size();
    run = 1'b1;
    for (int i = 0; i < BUDGET && obs_delay_q.size() < l0 + 2; i++) tick();
    delay = DW'(50);
    for (int i = 0; i < BUDGET && obs_delay_q.size() < l0 + 5; i++) tick();
    run = 1'b0;
    for (int i = 0; i < BUDGET && done_delay_q.size() < c0 + 5; i++) tick();
    tick(3);
    checks++; if (frame_count !== FW'(5)) begin failures++; $display("FAIL delay_frame_count: got %0d expected 5", frame_count); end
    checks++;
    if (obs_delay_q.size() < l0 + 5 || done_delay_q.size() < c0 + 2) begin
      failures++; $display("FAIL delay_records: got %0d launches expected 5", obs_delay_q.size() - l0);
    end else begin
      checks += 2;
      if (obs_delay_q[l0+1] !== DW'(7)) begin failures++; $display("FAIL delay_frame2: got %0d expected 7", obs_delay_q[l0+1]); end
      if (done_delay_q[c0+1] !== DW'(7)) begin failures++; $display("FAIL delay_frame2_hold: got %0d expected 7", done_delay_q[c0+1]); end
      if (obs_delay_q[l0+2] !== DW'(50)) begin failures++; $display("FAIL delay_frame3: got %0d expected 50", obs_delay_q[l0+2]); end
      for (int k = l0; k < l0 + 5; k++) begin
        checks++;
        if (obs_delay_q[k] !== exp_delay_q[k]) begin failures++; $display("FAIL delay_latch_%0d: got %0d expected %0d", k - l0, obs_delay_q[k], exp_delay_q[k]); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int d0, d1;
    bit to;
    do_reset();
    delay = DW'(5); step_lat = 1; draw_lat = 12;
    d0 = draw_starts;
    run = 1'b1;
    for (int i = 0; i < BUDGET && draw_starts < d0 + 1; i++) tick();
    run = 1'b0;
    tick(2);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midreset_busy_before: got %b expected 1", busy); end
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    checks++; if ({bus.limit_start, bus.step_start, bus.draw_start} !== 3'b000) begin failures++; $display("FAIL midreset_starts: got %b expected 000", {bus.limit_start, bus.step_start, bus.draw_start}); end
    checks++; if (bus.limit_delay !== '0) begin failures++; $display("FAIL midreset_limit_delay: got %0d expected 0", bus.limit_delay); end
    checks++; if (frame_count !== '0 || overrun_count !== '0) begin failures++; $display("FAIL midreset_counters: got %0d/%0d expected 0/0", frame_count, overrun_count); end
    tick(2);
    reset = 1'b0;
    d1 = draw_starts;
    tick(30);
    checks++; if (draw_starts !== d1) begin failures++; $display("FAIL midreset_no_draw: got %0d pulses expected 0", draw_starts - d1); end
    checks++; if (frame_count !== FW'(0)) begin failures++; $display("FAIL midreset_frame_count: got %0d expected 0", frame_count); end
    run_frames(1, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL midreset_timeout: got %b expected 0", to); end
    checks++; if (frame_count !== FW'(1)) begin failures++; $display("FAIL midreset_relaunch_count: got %0d expected 1", frame_count); end
    checks++; if (draw_starts - d1 !== 1) begin failures++; $display("FAIL midreset_relaunch_draw: got %0d expected 1", draw_starts - d1); end
  endtask

  task automatic test_run_drop();
    int l0, c0;
    do_reset();
    delay = DW'(4); step_lat = 3; draw_lat = 2;
    l0 = limit_starts; c0 = done_count;
    run = 1'b1;
    for (int i = 0; i < BUDGET && limit_starts < l0 + 1; i++) tick();
    tick(1);
    run = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rundrop_busy_mid: got %b expected 1", busy); end
    for (int i = 0; i < BUDGET && done_count < c0 + 1; i++) tick();
    tick(20);
    checks++; if (done_count - c0 !== 1) begin failures++; $display("FAIL rundrop_frame_done: got %0d expected 1", done_count - c0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rundrop_busy_after: got %b expected 0", busy); end
    checks++; if (limit_starts - l0 !== 1) begin failures++; $display("FAIL rundrop_launches: got %0d expected 1", limit_starts - l0); end
    checks++; if (frame_count !== FW'(1)) begin failures++; $display("FAIL rundrop_frame_count: got %0d expected 1", frame_count); end
  endtask

  task automatic test_random();
    int c0, e0, l0, n_obs, n_exp;
    bit to;
    do_reset();
    c0 = obs_done_q.size(); e0 = exp_done_q.size(); l0 = obs_delay_q.size();
    for (int it = 0; it < 10; it++) begin
      delay    = DW'($urandom_range(0, 20));
      step_lat = int'($urandom_range(0, 6));
      draw_lat = int'($urandom_range(0, 14));
      run_frames(int'($urandom_range(1, 3)), to);
      checks++; if (to !== 1'b0) begin failures++; $display("FAIL rand_timeout_%0d: got %b expected 0", it, to); end
      checks++; if (frame_count !== FW'(model_frames)) begin failures++; $display("FAIL rand_frame_count_%0d: got %0d expected %0d", it, frame_count, model_frames); end
      checks++; if (overrun_count !== FW'(model_overruns)) begin failures++; $display("FAIL rand_overrun_%0d: got %0d expected %0d", it, overrun_count, model_overruns); end
    end
    n_obs = obs_done_q.size() - c0;
    n_exp = exp_done_q.size() - e0;
    checks++; if (n_obs !== n_exp) begin failures++; $display("FAIL rand_done_count: got %0d expected %0d", n_obs, n_exp); end
    for (int k = 0; k < n_obs && k < n_exp; k++) begin
      checks++;
      if (obs_done_q[c0+k] !== exp_done_q[e0+k]) begin failures++; $display("FAIL rand_done_edge_%0d: got %0d expected %0d", k, obs_done_q[c0+k], exp_done_q[e0+k]); end
    end
    for (int k = l0; k < obs_delay_q.size(); k++) begin
      checks++;
      if (obs_delay_q[k] !== exp_delay_q[k]) begin failures++; $display("FAIL rand_delay_%0d: got %0d expected %0d", k - l0, obs_delay_q[k], exp_delay_q[k]); end
    end
  endtask

  task automatic test_wrap();
    int got[$];
    int ovr[$];
    int edges[$];
    int starts;
    starts = 0;
    do_reset();
    delay2 = '0;
    run2   = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (bus2.limit_start) begin
        starts++;
        if (starts >= 5) run2 = 1'b0;
      end
      if (frame_done2) begin
        got.push_back(int'(frame_count2));
        ovr.push_back(int'(overrun_count2));
        edges.push_back(cyc);
      end
    end
    run2 = 1'b0;
    checks++; if (starts !== 5) begin failures++; $display("FAIL wrap_launches: got %0d expected 5", starts); end
    checks++; if (got.size() !== 5) begin failures++; $display("FAIL wrap_done_count: got %0d expected 5", got.size()); end
    checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL wrap_busy_after: got %b expected 0", busy2); end
    for (int k = 0; k < got.size(); k++) begin
      checks += 2;
      if (got[k] !== (k + 1) % 4) begin failures++; $display("FAIL wrap_frame_count_%0d: got %0d expected %0d", k, got[k], (k + 1) % 4); end
      if (ovr[k] !== (k + 1) % 4) begin failures++; $display("FAIL wrap_overrun_%0d: got %0d expected %0d", k, ovr[k], (k + 1) % 4); end
      if (k > 0) begin
        checks++;
        if (edges[k] - edges[k-1] !== 6) begin failures++; $display("FAIL wrap_frame_len_%0d: got %0d expected 6", k, edges[k] - edges[k-1]); end
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    run    = 1'b0;
    run2   = 1'b0;
    delay  = '0;
    delay2 = '0;
    test_reset();
    test_single_frame();
    test_overrun();
    test_delay_change();
    test_reset_mid_frame();
    test_run_drop();
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameter DELAY_WIDTH, default 26, width of the frame delay value passed to the FPS limiter.
REQ-002 Parameter FRAME_WIDTH, default 16, width of frame and overrun counters.
REQ-003 clock  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 run  input  1  level enable; frames are launched while high.
REQ-006 delay  input  DELAY_WIDTH  per-frame limiter delay in clock cycles; sampled at frame launch.
REQ-007 limit_start / limit_finished  output 1 / input 1  start/finished handshake to the FPS limiter.
REQ-008 limit_delay  output  DELAY_WIDTH  registered delay presented to the limiter; stable from launch until the next launch.
REQ-009 step_start / step_finished  output 1 / input 1  handshake to the simulation-step unit.
REQ-010 draw_start / draw_finished  output 1 / input 1  handshake to the renderer.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 frame_done  output  1  one-cycle pulse at frame completion.
REQ-013 frame_count  output  FRAME_WIDTH  completed frames, wraps modulo 2^FRAME_WIDTH.
REQ-014 overrun_count  output  FRAME_WIDTH  frames whose draw ended after the limiter expired; wraps.

Function
REQ-015 Block SHALL be the initiator of the start/finished protocol: a start is a single-cycle pulse, issued only while the target's finished is 1; the target drops finished on the edge that samples start.
REQ-016 States SHALL be IDLE, LAUNCH, STEP_WAIT, DRAW_LAUNCH, DRAW_WAIT, SYNC.
REQ-017 IDLE: if run=1 and limit_finished=step_finished=draw_finished=1, SHALL go to LAUNCH and latch delay into limit_delay on that edge; otherwise stay.
REQ-018 LAUNCH: limit_start=1 and step_start=1 for exactly this one cycle; next state STEP_WAIT unconditionally.
REQ-019 STEP_WAIT: SHALL ignore step_finished on the first cycle (cycle after the pulse) only if still 1 from before the pulse is impossible by protocol; advance to DRAW_LAUNCH on first cycle step_finished=1.
REQ-020 DRAW_LAUNCH: draw_start=1 for exactly one cycle; next state DRAW_WAIT.
REQ-021 DRAW_WAIT: on draw_finished=1 go to SYNC; if limit_finished=1 in that same cycle, overrun_count SHALL increment by 1 on that edge.
REQ-022 SYNC: on limit_finished=1 SHALL pulse frame_done on the next cycle (registered), increment frame_count on that edge, and return to IDLE.
REQ-023 All start outputs SHALL be decoded from the state register only (Moore), never combinationally from inputs.
REQ-024 Minimum frame length SHALL be 6 cycles (IDLE..SYNC each at least one cycle) with zero-latency responders.
REQ-025 run falling mid-frame SHALL NOT abort: the frame completes, then the block stays in IDLE.
REQ-026 delay changing mid-frame SHALL NOT affect limit_delay until the next IDLE->LAUNCH edge.
REQ-027 delay=0 SHALL be legal; limiter completion is then waited for normally.
REQ-028 Counters SHALL wrap from all-ones to zero with no flag.

Reset
REQ-029 reset=1 SHALL immediately (asynchronously) force state IDLE, all start outputs 0, busy 0, frame_done 0, frame_count 0, overrun_count 0, limit_delay 0.
REQ-030 reset asserted mid-frame SHALL abandon the frame without incrementing any counter; after release, a new frame launches only per REQ-017.

Verification
REQ-031 Reset release, run=1, delay=10, limiter counts delay, step/draw respond in 2 cycles -> exactly one limit_start+step_start pulse, limit_delay=10, frame_done once, frame_count=1, overrun_count=0.
REQ-032 delay=3, draw takes 20 cycles -> overrun_count=1 after frame, frame_count=1, no extra start pulses.
REQ-033 run=1 for 5 frames, delay changed to 50 during frame 2 -> frame 2 limit_delay unchanged, frame 3 limit_delay=50, frame_count=5.
REQ-034 reset pulsed while in DRAW_WAIT -> outputs zeroed same cycle, frame_count stays 0, draw_start not re-pulsed until new launch.
REQ-035 FRAME_WIDTH=2, 5 frames -> frame_count sequence 1,2,3,0,1.
REQ-036 run dropped during STEP_WAIT -> frame completes (frame_done once), busy then 0 and no further limit_start.
